// File: rtl/beamformer_pkg.sv
// Shared types and constants for the delay-and-sum beamformer.
package beamformer_pkg;

   typedef enum logic [2:0] {IDLE, CAPTURE, WRITE, READ, DONE} bf_state_t;

   localparam int unsigned NUM_CH       = 4;
   localparam logic [7:0]  ADC_MIDSCALE = 8'h80;

   // Offset-binary ADC code -> two's complement, sign-extended to the accumulator width.
   function automatic logic signed [9:0] centre_sample(input logic [7:0] s);
      logic [7:0] c;
      c = s ^ ADC_MIDSCALE;
      return {{2{c[7]}}, c};
   endfunction

endpackage

// File: rtl/delay_sum_beamformer_if.sv
// Sampler-facing and output-facing signals of the beamformer.
interface delay_sum_beamformer_if #(
   parameter int unsigned DLY_W = 5
);
   logic [7:0]         ch0, ch1, ch2, ch3;
   logic               newSample;
   logic [DLY_W-1:0]   delay0, delay1, delay2, delay3;
   logic [3:0]         chan_en;
   logic signed [9:0]  beam_out;
   logic               beam_valid;
   logic               busy;
   logic               overrun;

   modport master (
      output ch0, ch1, ch2, ch3, newSample, delay0, delay1, delay2, delay3, chan_en,
      input  beam_out, beam_valid, busy, overrun
   );

   modport slave (
      input  ch0, ch1, ch2, ch3, newSample, delay0, delay1, delay2, delay3, chan_en,
      output beam_out, beam_valid, busy, overrun
   );
endinterface

// File: rtl/sample_ring_ram.sv
// Simple dual-port sample history RAM: one write port, one read port, 1-clk read latency.
module sample_ring_ram #(
   parameter int unsigned AW = 7,
   parameter int unsigned DW = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end
endmodule

// File: rtl/delay_sum_beamformer.sv
// Delay-and-sum beamformer: per-channel ring-buffer history, programmable delays, signed sum.
module delay_sum_beamformer
   import beamformer_pkg::*;
#(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned DLY_W = 5
) (
   input logic                   clk,
   input logic                   reset,
   delay_sum_beamformer_if.slave bus
);
   localparam int unsigned AW = $clog2(NUM_CH) + DLY_W;

   bf_state_t          state;
   logic               ns_q;
   logic               rise;
   logic [2:0]         step;
   logic [DLY_W-1:0]   wr_ptr;
   logic [DLY_W:0]     fill;
   logic [7:0]         ch_in [NUM_CH];
   logic [DLY_W-1:0]   dly_in [NUM_CH];
   logic [7:0]         ch_s [NUM_CH];
   logic [DLY_W-1:0]   dly_s [NUM_CH];
   logic [NUM_CH-1:0]  en_s;
   logic signed [9:0]  acc;
   logic signed [9:0]  beam_q;
   logic               valid_q;
   logic               busy_q;
   logic               overrun_q;

   logic               ram_we;
   logic [AW-1:0]      ram_waddr;
   logic [7:0]         ram_wdata;
   logic [AW-1:0]      ram_raddr;
   logic [7:0]         ram_rdata;
   logic [DLY_W-1:0]   rd_ptr;
   logic [1:0]         prev;
   logic signed [9:0]  term;

   assign rise = bus.newSample & ~ns_q;

   assign ch_in[0]  = bus.ch0;
   assign ch_in[1]  = bus.ch1;
   assign ch_in[2]  = bus.ch2;
   assign ch_in[3]  = bus.ch3;
   assign dly_in[0] = bus.delay0;
   assign dly_in[1] = bus.delay1;
   assign dly_in[2] = bus.delay2;
   assign dly_in[3] = bus.delay3;

   sample_ring_ram #(
      .AW (AW),
      .DW (8)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (ram_raddr),
      .rdata (ram_rdata)
   );

   always_comb begin
      ram_we    = (state == WRITE);
      ram_waddr = {step[1:0], wr_ptr};
      ram_wdata = ch_s[step[1:0]];
      // wr_ptr already advanced, so the newest sample sits at wr_ptr - 1.
      rd_ptr    = wr_ptr - DLY_W'(1) - dly_s[step[1:0]];
      ram_raddr = {step[1:0], rd_ptr};
      // Data returned this cycle belongs to the read issued one step earlier.
      prev      = 2'(step - 3'd1);
      term      = '0;
      if (en_s[prev] && ({1'b0, dly_s[prev]} < fill)) term = centre_sample(ram_rdata);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         ns_q      <= 1'b0;
         step      <= '0;
         wr_ptr    <= '0;
         fill      <= '0;
         acc       <= '0;
         beam_q    <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
         en_s      <= '0;
         for (int k = 0; k < NUM_CH; k++) begin
            ch_s[k]  <= '0;
            dly_s[k] <= '0;
         end
      end else begin
         ns_q    <= bus.newSample;
         valid_q <= 1'b0;
         if (rise && (state != IDLE)) overrun_q <= 1'b1;
         case (state)
            IDLE: begin
               if (rise) begin
                  state  <= CAPTURE;
                  busy_q <= 1'b1;
               end
            end
            CAPTURE: begin
               for (int k = 0; k < NUM_CH; k++) begin
                  ch_s[k]  <= ch_in[k];
                  dly_s[k] <= dly_in[k];
               end
               en_s  <= bus.chan_en;
               acc   <= '0;
               step  <= '0;
               state <= WRITE;
            end
            WRITE: begin
               if (step == 3'd3) begin
                  wr_ptr <= wr_ptr + DLY_W'(1);
                  if (fill != (DLY_W+1)'(DEPTH)) fill <= fill + (DLY_W+1)'(1);
                  step   <= '0;
                  state  <= READ;
               end else begin
                  step <= step + 3'd1;
               end
            end
            READ: begin
               if (step != 3'd0) acc <= acc + term;
               if (step == 3'd4) begin
                  beam_q  <= acc + term;
                  valid_q <= 1'b1;
                  step    <= '0;
                  state   <= DONE;
               end else begin
                  step <= step + 3'd1;
               end
            end
            DONE: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.beam_out   = beam_q;
   assign bus.beam_valid = valid_q;
   assign bus.busy       = busy_q;
   assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_delay_sum_beamformer.sv
// Directed bench for delay_sum_beamformer with hand-computed expected beam values.
module tb_delay_sum_beamformer;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   tests = 0;
   int   fails = 0;
   int   lat, val, cnt;

   always #5 clk = ~clk;

   delay_sum_beamformer_if #(.DLY_W(5)) bus ();

   delay_sum_beamformer #(
      .DEPTH (32),
      .DLY_W (5)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic set_cfg(input logic [4:0] d0, d1, d2, d3, input logic [3:0] en);
      bus.delay0  = d0;
      bus.delay1  = d1;
      bus.delay2  = d2;
      bus.delay3  = d3;
      bus.chan_en = en;
   endtask

   task automatic set_ch(input logic [7:0] a, b, c, d);
      bus.ch0 = a;
      bus.ch1 = b;
      bus.ch2 = c;
      bus.ch3 = d;
   endtask

   // Raise newSample (held 2 clk), report cycles to beam_valid (-1 on timeout) and beam_out.
   task automatic run_pass(input logic [7:0] a, b, c, d, output int l, output int v);
      logic found;
      found = 1'b0;
      l = -1;
      v = 9999;
      set_ch(a, b, c, d);
      bus.newSample = 1'b1;
      for (int i = 1; i <= 20 && !found; i++) begin
         tick();
         if (i == 2) bus.newSample = 1'b0;
         if (bus.beam_valid) begin
            found = 1'b1;
            l = i;
            v = int'(bus.beam_out);
         end
      end
      bus.newSample = 1'b0;
      tick();
   endtask

   initial begin
      bus.newSample = 1'b0;
      set_ch(8'h80, 8'h80, 8'h80, 8'h80);
      set_cfg(5'd0, 5'd0, 5'd0, 5'd0, 4'hF);
      tick();
      tick();
      reset = 1'b0;

      check("rst_beam_out", int'(bus.beam_out), 0);
      check("rst_beam_valid", int'(bus.beam_valid), 0);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_overrun", int'(bus.overrun), 0);

      // Mid-scale input on every channel sums to zero, 11 clk after the rise.
      for (int p = 0; p < 2; p++) begin
         run_pass(8'h80, 8'h80, 8'h80, 8'h80, lat, val);
         check("t1_latency", lat, 11);
         check("t1_beam", val, 0);
      end

      // Full-scale extremes.
      run_pass(8'hFF, 8'hFF, 8'hFF, 8'hFF, lat, val);
      check("t2_pos_full", val, 508);
      run_pass(8'h00, 8'h00, 8'h00, 8'h00, lat, val);
      check("t2_neg_full", val, -512);

      // Impulse on ch0 at sample 1, delay0 = 3: only output 4 sees it.
      do_reset();
      set_cfg(5'd3, 5'd0, 5'd0, 5'd0, 4'h1);
      for (int p = 0; p < 7; p++) begin
         run_pass((p == 1) ? 8'h90 : 8'h80, 8'h00, 8'h00, 8'h00, lat, val);
         check("t3_impulse", val, (p == 4) ? 16 : 0);
      end

      // Delay beyond filled history reads zero; then wrap the write pointer.
      do_reset();
      set_cfg(5'd0, 5'd5, 5'd0, 5'd0, 4'h2);
      for (int p = 0; p < 40; p++) begin
         run_pass(8'hFF, 8'hA0, 8'h00, 8'h00, lat, val);
         check("t4_delay5", val, (p >= 5) ? 32 : 0);
      end
      set_cfg(5'd0, 5'd31, 5'd0, 5'd0, 4'h2);
      for (int p = 0; p < 3; p++) begin
         run_pass(8'hFF, 8'hA0, 8'h00, 8'h00, lat, val);
         check("t4_delay31_wrap", val, 32);
      end
      check("t4_no_overrun", int'(bus.overrun), 0);

      // Second rise 4 clk into a pass is dropped and flags overrun.
      set_cfg(5'd0, 5'd0, 5'd0, 5'd0, 4'hF);
      set_ch(8'h80, 8'h80, 8'h80, 8'h80);
      cnt = 0;
      bus.newSample = 1'b1;
      for (int i = 1; i <= 30; i++) begin
         tick();
         if (i == 1) bus.newSample = 1'b0;
         if (i == 2) check("t5_busy", int'(bus.busy), 1);
         if (i == 4) bus.newSample = 1'b1;
         if (i == 5) bus.newSample = 1'b0;
         if (bus.beam_valid) cnt++;
      end
      check("t5_valid_count", cnt, 1);
      check("t5_overrun_set", int'(bus.overrun), 1);
      run_pass(8'h80, 8'h80, 8'h80, 8'h80, lat, val);
      check("t5_overrun_sticky", int'(bus.overrun), 1);
      do_reset();
      check("t5_overrun_cleared", int'(bus.overrun), 0);

      // Reset during READ aborts; the next pass sees an empty history.
      set_cfg(5'd0, 5'd0, 5'd0, 5'd0, 4'hF);
      set_ch(8'hFF, 8'hFF, 8'hFF, 8'hFF);
      cnt = 0;
      bus.newSample = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         tick();
         if (i == 1) bus.newSample = 1'b0;
         if (bus.beam_valid) cnt++;
      end
      reset = 1'b1;
      tick();
      check("t6_no_valid_before_abort", cnt, 0);
      check("t6_beam_out", int'(bus.beam_out), 0);
      check("t6_beam_valid", int'(bus.beam_valid), 0);
      check("t6_busy", int'(bus.busy), 0);
      check("t6_overrun", int'(bus.overrun), 0);
      reset = 1'b0;
      tick();
      set_cfg(5'd1, 5'd0, 5'd0, 5'd0, 4'h1);
      run_pass(8'hFF, 8'h00, 8'h00, 8'h00, lat, val);
      check("t6_first_latency", lat, 11);
      check("t6_first_empty", val, 0);
      run_pass(8'h80, 8'h00, 8'h00, 8'h00, lat, val);
      check("t6_second_history", val, 127);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
